load_store_unit: RTL and testbench

//  Initiator side of the data-memory interface: takes one load/store request per transaction from the core
//  and drives the word-addressed, synchronous-read, single-port data RAM (write_enable/chip_select/address/data).

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//  - funct3 encodings for RV32I loads/stores
//  - FSM state type
//  - alignment / legality helpers used at request accept time
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ      = 3'd1,
      ST_READ_WAIT = 3'd2,
      ST_WRITE     = 3'd3,
      ST_RESP      = 3'd4
   } lsu_state_t;

   // Access size comes from funct3[1:0]; the unsigned bit (funct3[2]) does not affect alignment.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = lo[0];
         2'b10:   mis = (lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
   function automatic logic is_illegal(input logic we, input logic [2:0] f3);
      logic ill;
      if (we) ill = (f3 > F3_W);
      else    ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      return ill;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for 32-bit sub-word accesses.
//  funct3     in   access type (B/H/W/BU/HU)
//  lane       in   byte offset within the word (addr[1:0])
//  mem_word   in   word read from RAM
//  store_data in   store data; low byte/half used for SB/SH
//  load_data  out  extracted and sign/zero-extended load result
//  merge_data out  mem_word with the addressed lane replaced by store_data
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] mem_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = mem_word[{lane, 3'b000} +: 8];
      half_v = lane[1] ? mem_word[31:16] : mem_word[15:0];
      case (funct3)
         F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
         F3_BU:   load_data = {24'd0, byte_v};
         F3_H:    load_data = {{16{half_v[15]}}, half_v};
         F3_HU:   load_data = {16'd0, half_v};
         default: load_data = mem_word;
      endcase
   end

   always_comb begin
      merge_data = mem_word;
      case (funct3[1:0])
         2'b00: merge_data[{lane, 3'b000} +: 8] = store_data[7:0];
         2'b01: begin
            if (lane[1]) merge_data[31:16] = store_data[15:0];
            else         merge_data[15:0]  = store_data[15:0];
         end
         default: merge_data = store_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator for RV32I loads/stores.
//  clk_i/rst_ni           clock, async active-low reset
//  req_*                  one request per transaction (valid/ready handshake)
//  rsp_valid_o            one-cycle completion pulse with rsp_rdata_o / rsp_err_o
//  mem_*                  word-addressed, synchronous-read single-port RAM port
// Sub-word stores are done as read-modify-write; one transaction outstanding.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [2:0]           req_funct3_i,
   input  logic [ADDRWIDTH+1:0] req_addr_i,
   input  logic [DATAWIDTH-1:0] req_wdata_i,
   output logic                 rsp_valid_o,
   output logic [DATAWIDTH-1:0] rsp_rdata_o,
   output logic                 rsp_err_o,
   output logic                 mem_write_enable_o,
   output logic                 mem_chip_select_o,
   output logic [ADDRWIDTH-1:0] mem_address_o,
   output logic [DATAWIDTH-1:0] mem_data_o,
   input  logic [DATAWIDTH-1:0] mem_data_i
);

   if (DATAWIDTH != 32) begin : g_width_check
      $error("load_store_unit: only DATAWIDTH=32 is supported");
   end

   lsu_state_t             state;
   logic                   we_q;
   logic [2:0]             f3_q;
   logic [ADDRWIDTH+1:0]   addr_q;
   logic [DATAWIDTH-1:0]   wdata_q;
   logic [DATAWIDTH-1:0]   rdata_q;
   logic                   err_q;
   logic [31:0]            load_data;
   logic [31:0]            merge_data;
   logic                   req_err;

   assign req_err = is_illegal(req_we_i, req_funct3_i) | is_misaligned(req_funct3_i, req_addr_i[1:0]);

   lsu_align u_align (
      .funct3     (f3_q),
      .lane       (addr_q[1:0]),
      .mem_word   (mem_data_i),
      .store_data (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  we_q    <= req_we_i;
                  f3_q    <= req_funct3_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  if (req_err) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                     state   <= ST_RESP;
                  end else if (req_we_i && req_funct3_i == F3_W) begin
                     state   <= ST_WRITE;
                  end else begin
                     state   <= ST_READ;
                  end
               end
            end
            ST_READ: state <= ST_READ_WAIT;
            ST_READ_WAIT: begin
               // RAM word is valid this cycle: either finish the load or merge the store lane
               if (we_q) begin
                  wdata_q <= merge_data;
                  state   <= ST_WRITE;
               end else begin
                  rdata_q <= load_data;
                  err_q   <= 1'b0;
                  state   <= ST_RESP;
               end
            end
            ST_WRITE: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
               state   <= ST_RESP;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode from state and latched registers only.
   assign req_ready_o        = (state == ST_IDLE) & rst_ni;
   assign rsp_valid_o        = (state == ST_RESP);
   assign rsp_rdata_o        = rdata_q;
   assign rsp_err_o          = err_q;
   assign mem_chip_select_o  = (state == ST_READ) | (state == ST_WRITE);
   assign mem_write_enable_o = (state == ST_WRITE);
   assign mem_address_o      = addr_q[ADDRWIDTH+1:2];
   assign mem_data_o         = (state == ST_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit.
// A byte-array reference memory predicts each response; a monitor checks
// responses, latency, RAM cycles and handshake behaviour independently.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [2:0]  req_funct3_i = 3'd0;
   logic [6:0]  req_addr_i = 7'd0;
   logic [31:0] req_wdata_i = 32'd0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        mem_write_enable_o;
   logic        mem_chip_select_o;
   logic [4:0]  mem_address_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;

   always #5 clk = ~clk;

   load_store_unit #(.DATAWIDTH(32), .ADDRWIDTH(5)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .mem_write_enable_o(mem_write_enable_o), .mem_chip_select_o(mem_chip_select_o),
      .mem_address_o(mem_address_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
   );

   // synchronous-read single-port RAM
   logic [31:0] ram [32];
   logic [31:0] init_w [32];
   logic [31:0] ram_q = 32'd0;
   bit          load_ram = 1'b0;
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < 32; i++) ram[i] <= init_w[i];
      end else if (mem_chip_select_o) begin
         if (mem_write_enable_o) ram[mem_address_o] <= mem_data_o;
         else                    ram_q <= ram[mem_address_o];
      end
   end
   assign mem_data_i = ram_q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model: byte-addressed little-endian memory
   logic [7:0] refb [128];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          cs;
      bit          chk_wr;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } exp_t;
   exp_t exp_q[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input int w);
      return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
   endfunction

   // monitor
   bit          manual = 1'b1;
   bit          rsp_prev = 1'b0;
   int          cs_cnt = 0;
   int          acc_cyc = 0;
   int          accepts = 0;
   int          issued = 0;
   logic [4:0]  mon_wa = 5'd0;
   logic [31:0] mon_wd = 32'd0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (manual || !rst_ni) begin
         rsp_prev = 1'b0;
      end else begin
         if (!mem_write_enable_o && mem_data_o != 32'd0) check("mem_data_zero_when_no_write", mem_data_o, 32'd0);
         if (rsp_prev) check("ready_after_resp", 32'(req_ready_o), 32'd1);
         rsp_prev = rsp_valid_o;
         if (mem_chip_select_o) begin
            cs_cnt++;
            if (mem_write_enable_o) begin
               mon_wa = mem_address_o;
               mon_wd = mem_data_o;
            end
         end
         if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("rdata", rsp_rdata_o, mon_e.rdata);
               check("err", 32'(rsp_err_o), 32'(mon_e.err));
               check("latency", 32'(cyc - acc_cyc + 1), 32'(mon_e.lat));
               check("cs_cycles", 32'(cs_cnt), 32'(mon_e.cs));
               if (mon_e.chk_wr) begin
                  check("wr_addr", 32'(mon_wa), 32'(mon_e.waddr));
                  check("wr_data", mon_wd, mon_e.wdata);
               end
            end
         end
         if (req_valid_i && req_ready_o) begin
            acc_cyc = cyc + 1;
            cs_cnt  = 0;
            accepts++;
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                        input logic [31:0] wd, input bit hold);
      exp_t        e;
      int          sz, n, base;
      logic [63:0] v;
      bit          ill, mis;
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wd;
      n = 0;
      @(negedge clk);
      while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
      if (!req_ready_o) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid_i = 1'b0;
         return;
      end
      sz   = 1 << f3[1:0];
      ill  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
      mis  = (int'(addr) % sz) != 0;
      base = int'(addr) & ~3;
      e.err = ill || mis; e.rdata = 32'd0; e.chk_wr = 1'b0; e.waddr = addr[6:2]; e.wdata = 32'd0;
      if (e.err) begin
         e.lat = 1; e.cs = 0;
      end else if (we) begin
         for (int i = 0; i < sz; i++) refb[int'(addr) + i] = wd[8*i +: 8];
         e.lat = (sz == 4) ? 2 : 4;
         e.cs  = (sz == 4) ? 1 : 2;
         e.chk_wr = 1'b1;
         e.wdata = ref_word(base / 4);
      end else begin
         v = 64'd0;
         for (int i = 0; i < sz; i++) v = v | (64'(refb[int'(addr) + i]) << (8 * i));
         if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
         e.rdata = v[31:0];
         e.lat = 3; e.cs = 1;
      end
      exp_q.push_back(e);
      issued++;
      @(posedge clk); #1;
      if (!hold) req_valid_i = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
      if (!rsp_valid_o) check("rsp_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int w = 0; w < 32; w++) begin
         init_w[w] = $urandom;
         for (int b = 0; b < 4; b++) refb[4*w+b] = init_w[w][8*b +: 8];
      end
      load_ram = 1'b1;
      repeat (2) @(posedge clk);
      #1 load_ram = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(req_ready_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      check("rst_rdata", rsp_rdata_o, 32'd0);
      check("rst_cs", 32'(mem_chip_select_o), 32'd0);
      check("rst_we", 32'(mem_write_enable_o), 32'd0);
      check("rst_addr", 32'(mem_address_o), 32'd0);
      check("rst_wdata", mem_data_o, 32'd0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      manual = 1'b0;

      // directed sequence
      issue(1'b1, 3'b010, 7'h08, 32'hDEADBEEF, 1'b0);
      check("sw_ram_word", ram[2], 32'hDEADBEEF);
      issue(1'b0, 3'b000, 7'h0B, 32'd0, 1'b0);
      issue(1'b0, 3'b100, 7'h0B, 32'd0, 1'b0);
      issue(1'b0, 3'b001, 7'h0A, 32'd0, 1'b0);
      issue(1'b0, 3'b010, 7'h08, 32'd0, 1'b0);
      issue(1'b1, 3'b000, 7'h09, 32'h00000012, 1'b0);
      check("sb_ram_word", ram[2], 32'hDEAD12EF);
      issue(1'b0, 3'b010, 7'h08, 32'd0, 1'b0);
      issue(1'b0, 3'b010, 7'h06, 32'd0, 1'b0);
      issue(1'b1, 3'b001, 7'h03, 32'h0000ABCD, 1'b0);
      issue(1'b0, 3'b011, 7'h00, 32'd0, 1'b0);

      // valid held high across busy cycles: one accept per transaction
      issue(1'b1, 3'b001, 7'h22, 32'h00005A5A, 1'b1);
      issue(1'b0, 3'b101, 7'h22, 32'd0, 1'b1);
      issue(1'b1, 3'b010, 7'h24, 32'h13579BDF, 1'b1);
      issue(1'b0, 3'b000, 7'h27, 32'd0, 1'b1);
      @(posedge clk); #1 req_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      check("accepts_vs_issued", 32'(accepts), 32'(issued));

      // reset during READ_WAIT of an SB: no write reaches the RAM
      manual = 1'b1;
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b000; req_addr_i = 7'h11; req_wdata_i = 32'h000000A5;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      check("rmw_read_cs", 32'(mem_chip_select_o), 32'd1);
      @(posedge clk); #1;
      rst_ni = 1'b0;
      #1;
      check("mid_rst_ready", 32'(req_ready_o), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("mid_rst_cs", 32'(mem_chip_select_o), 32'd0);
      check("mid_rst_we", 32'(mem_write_enable_o), 32'd0);
      check("mid_rst_addr", 32'(mem_address_o), 32'd0);
      check("mid_rst_wdata", mem_data_o, 32'd0);
      check("mid_rst_rdata", rsp_rdata_o, 32'd0);
      repeat (3) @(posedge clk);
      check("rst_ram_unchanged", ram[4], ref_word(4));
      #1 rst_ni = 1'b1;
      manual = 1'b0;
      issue(1'b0, 3'b010, 7'h10, 32'd0, 1'b0);

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
               $urandom, 1'($urandom_range(0, 1)));
      end
      @(posedge clk); #1 req_valid_i = 1'b0;
      repeat (4) @(posedge clk);
      check("final_accepts", 32'(accepts), 32'(issued));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      for (int w = 0; w < 32; w++) check($sformatf("ram_word_%0d", w), ram[w], ref_word(w));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
